// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Turns a debounced, active-low button level into one-cycle gesture events:
// press / release edges, single click, double click and long press.
// Time is measured in prescaler ticks; one tick occurs every 2**TICK_BITS
// clocks, when the free-running prescaler reads all ones.
//
// Ports
//   clock          in   single clock, everything on the rising edge
//   reset_n        in   synchronous active-low reset
//   level          in   debounced button level (0 = pressed, 1 = released)
//   press_pulse    out  one cycle per press edge
//   release_pulse  out  one cycle per release edge
//   click          out  one cycle when a single short click completes
//   double_click   out  one cycle on the second press of a double click
//   long_press     out  one cycle when a hold reaches LONG_TICKS ticks
//   held           out  high while the registered level is 0
//
// Handshake: none. Inputs are sampled every clock; every output is a flop
// and each pulse is high for exactly one cycle.
// -----------------------------------------------------------------------------
module button_event_decoder #(
   parameter int TICK_BITS    = 10,
   parameter int LONG_TICKS   = 500,
   parameter int DCLICK_TICKS = 200
) (
   input  logic clock,
   input  logic reset_n,
   input  logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic click,
   output logic double_click,
   output logic long_press,
   output logic held
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DOWN1 = 3'd1,
      S_WAIT2 = 3'd2,
      S_DOWN2 = 3'd3,
      S_LONG  = 3'd4
   } state_t;

   localparam logic [9:0] LONG_LAST   = 10'(LONG_TICKS - 1);
   localparam logic [9:0] DCLICK_LAST = 10'(DCLICK_TICKS - 1);
   localparam logic [9:0] TCNT_MAX    = 10'h3FF;

   // Two-stage level pipeline: level_q is the newer sample, level_d the older.
   logic                 level_q;
   logic                 level_d;

   state_t               state_q, state_d;
   logic [TICK_BITS-1:0] presc_q, presc_d;
   logic [9:0]           tcnt_q, tcnt_d;

   logic press_pulse_q,   press_pulse_d;
   logic release_pulse_q, release_pulse_d;
   logic click_q,         click_d;
   logic double_click_q,  double_click_d;
   logic long_press_q,    long_press_d;
   logic held_q,          held_d;

   logic press_edge;
   logic release_edge;
   logic tick;

   always_comb begin
      press_edge   = ~level_q &  level_d;
      release_edge =  level_q & ~level_d;
      tick         = &presc_q;

      presc_d         = presc_q + TICK_BITS'(1);
      press_pulse_d   = press_edge;
      release_pulse_d = release_edge;
      held_d          = ~level_q;

      state_d        = state_q;
      click_d        = 1'b0;
      double_click_d = 1'b0;
      long_press_d   = 1'b0;

      // Within each state the edge is tested first, so an edge that lands on
      // the same cycle as a timeout always takes priority over the timeout.
      case (state_q)
         S_IDLE: begin
            if (press_edge) state_d = S_DOWN1;
         end
         S_DOWN1: begin
            if (release_edge) begin
               state_d = S_WAIT2;
            end else if (tick && (tcnt_q == LONG_LAST)) begin
               state_d      = S_LONG;
               long_press_d = 1'b1;
            end
         end
         S_WAIT2: begin
            if (press_edge) begin
               state_d        = S_DOWN2;
               double_click_d = 1'b1;
            end else if (tick && (tcnt_q == DCLICK_LAST)) begin
               state_d = S_IDLE;
               click_d = 1'b1;
            end
         end
         S_DOWN2: begin
            if (release_edge) state_d = S_IDLE;
         end
         S_LONG: begin
            if (release_edge) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // tcnt measures ticks spent in the current state.
      if (state_d != state_q) begin
         tcnt_d = '0;
      end else if (tick && (tcnt_q != TCNT_MAX)) begin
         tcnt_d = tcnt_q + 10'd1;
      end else begin
         tcnt_d = tcnt_q;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         level_q         <= 1'b1;
         level_d         <= 1'b1;
         state_q         <= S_IDLE;
         presc_q         <= '0;
         tcnt_q          <= '0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         click_q         <= 1'b0;
         double_click_q  <= 1'b0;
         long_press_q    <= 1'b0;
         held_q          <= 1'b0;
      end else begin
         level_q         <= level;
         level_d         <= level_q;
         state_q         <= state_d;
         presc_q         <= presc_d;
         tcnt_q          <= tcnt_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         click_q         <= click_d;
         double_click_q  <= double_click_d;
         long_press_q    <= long_press_d;
         held_q          <= held_d;
      end
   end

   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign click         = click_q;
   assign double_click  = double_click_q;
   assign long_press    = long_press_q;
   assign held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//
// Drives button_event_decoder with directed gesture scenarios, timing sweeps
// that line edges up against tick expiries, and randomized level runs with
// occasional resets. Every cycle all six outputs are compared with a
// gesture-level reference model; scenario-level event counts are checked too.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

   localparam int TB_TICK_BITS = 2;
   localparam int TB_LONG      = 5;
   localparam int TB_DCLICK    = 3;
   localparam int TICK_PERIOD  = 1 << TB_TICK_BITS;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n;
   logic level;
   logic press_pulse, release_pulse, click, double_click, long_press, held;

   always #5 clock = ~clock;

   button_event_decoder #(
      .TICK_BITS    (TB_TICK_BITS),
      .LONG_TICKS   (TB_LONG),
      .DCLICK_TICKS (TB_DCLICK)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .level         (level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .click         (click),
      .double_click  (double_click),
      .long_press    (long_press),
      .held          (held)
   );

   // ---------------- scoreboard counters ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Gesture phases described in user terms, not in the DUT's encoding.
   typedef enum int {G_IDLE, G_FIRST_DOWN, G_GAP, G_SECOND_DOWN, G_LONG_HELD} gest_t;

   gest_t g_phase;
   int    m_new, m_old;      // last two level samples (newest first)
   int    m_clocks;          // clocks since reset, drives tick timing
   int    m_ticks;           // ticks seen since entering current phase
   int    cov_033, cov_035;  // edge/timeout coincidences exercised
   logic  e_press, e_rel, e_click, e_dclick, e_long, e_held;

   task automatic model_step(input logic lvl, input logic rn);
      bit    pe, re, tk;
      gest_t nxt;
      if (!rn) begin
         g_phase = G_IDLE; m_new = 1; m_old = 1; m_clocks = 0; m_ticks = 0;
         {e_press, e_rel, e_click, e_dclick, e_long, e_held} = '0;
      end else begin
         pe = (m_new == 0) && (m_old == 1);
         re = (m_new == 1) && (m_old == 0);
         tk = (m_clocks % TICK_PERIOD) == (TICK_PERIOD - 1);
         m_clocks++;
         e_press = pe; e_rel = re; e_held = (m_new == 0);
         e_click = 0; e_dclick = 0; e_long = 0;
         nxt = g_phase;
         case (g_phase)
            G_IDLE:        if (pe) nxt = G_FIRST_DOWN;
            G_FIRST_DOWN: begin
               if (re) begin
                  nxt = G_GAP;
                  if (tk && (m_ticks + 1 == TB_LONG)) cov_033++;
               end else if (tk && (m_ticks + 1 == TB_LONG)) begin
                  nxt = G_LONG_HELD; e_long = 1;
               end
            end
            G_GAP: begin
               if (pe) begin
                  nxt = G_SECOND_DOWN; e_dclick = 1;
                  if (tk && (m_ticks + 1 == TB_DCLICK)) cov_035++;
               end else if (tk && (m_ticks + 1 == TB_DCLICK)) begin
                  nxt = G_IDLE; e_click = 1;
               end
            end
            G_SECOND_DOWN: if (re) nxt = G_IDLE;
            G_LONG_HELD:   if (re) nxt = G_IDLE;
            default:       nxt = G_IDLE;
         endcase
         if (nxt != g_phase) m_ticks = 0;
         else if (tk && m_ticks < 1023) m_ticks++;
         g_phase = nxt;
         m_old = m_new;
         m_new = int'(lvl);
      end
   endtask

   // ---------------- driver ----------------
   int c_press, c_rel, c_click, c_dclick, c_long;

   task automatic clear_counts();
      c_press = 0; c_rel = 0; c_click = 0; c_dclick = 0; c_long = 0;
   endtask

   // One clock: drive at negedge, model at posedge, compare #1 later.
   task automatic step(input logic lvl, input logic rn);
      level   = lvl;
      reset_n = rn;
      @(posedge clock);
      model_step(lvl, rn);
      #1;
      chk("press_pulse",   32'(press_pulse),   32'(e_press));
      chk("release_pulse", 32'(release_pulse), 32'(e_rel));
      chk("click",         32'(click),         32'(e_click));
      chk("double_click",  32'(double_click),  32'(e_dclick));
      chk("long_press",    32'(long_press),    32'(e_long));
      chk("held",          32'(held),          32'(e_held));
      chk("one_gesture",   32'((32'(click) + 32'(double_click) + 32'(long_press)) <= 1), 32'd1);
      c_press  += int'(press_pulse);
      c_rel    += int'(release_pulse);
      c_click  += int'(click);
      c_dclick += int'(double_click);
      c_long   += int'(long_press);
      @(negedge clock);
   endtask

   task automatic run(input logic lvl, input int n);
      for (int i = 0; i < n; i++) step(lvl, 1'b1);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   int lat;

   initial begin
      cov_033 = 0; cov_035 = 0;
      level = 1'b1; reset_n = 1'b0;
      @(negedge clock);
      do_reset(3);
      run(1'b1, 4);

      // Single short click.
      clear_counts();
      run(1'b0, 8); run(1'b1, 20);
      chk("s030_press", c_press, 1);   chk("s030_release", c_rel, 1);
      chk("s030_click", c_click, 1);   chk("s030_dclick", c_dclick, 0);
      chk("s030_long", c_long, 0);

      // Long hold.
      clear_counts();
      run(1'b0, 40); run(1'b1, 20);
      chk("s031_long", c_long, 1);     chk("s031_click", c_click, 0);
      chk("s031_release", c_rel, 1);

      // Double click.
      clear_counts();
      run(1'b0, 4); run(1'b1, 4); run(1'b0, 4); run(1'b1, 20);
      chk("s032_dclick", c_dclick, 1); chk("s032_click", c_click, 0);
      chk("s032_press", c_press, 2);   chk("s032_long", c_long, 0);

      // Release against long expiry: fixed prescaler phase, sweep hold length.
      for (int l = 14; l <= 24; l++) begin
         do_reset(2); run(1'b1, 3);
         run(1'b0, l); run(1'b1, 20);
      end
      chk("cov_033", 32'(cov_033 > 0), 32'd1);

      // Second press against click timeout: sweep gap length.
      for (int g = 6; g <= 14; g++) begin
         do_reset(2); run(1'b1, 3);
         run(1'b0, 3); run(1'b1, g); run(1'b0, 3); run(1'b1, 20);
      end
      chk("cov_035", 32'(cov_035 > 0), 32'd1);

      // Reset during a press with the button still held.
      run(1'b1, 4);
      run(1'b0, 6);
      do_reset(2);
      clear_counts();
      lat = 0;
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 1'b1);
         if (press_pulse && lat == 0) lat = i;
      end
      // Pulse lands on the second edge after release, i.e. three clock
      // edges counting the one at which reset_n was still low.
      chk("s034_latency", lat, 2);
      chk("s034_press", c_press, 1);
      run(1'b1, 20);

      // Randomized level runs with occasional resets.
      for (int s = 0; s < 250; s++) begin
         if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
         run(1'($urandom_range(0, 1)), $urandom_range(1, 30));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
